// File: rtl/branch_stat_ctrl.sv
// Branch resolution statistics: windowed total/mispredict/cycle counts
// with snapshot registers and a one-cycle-latency read port.
module branch_stat_ctrl #(
  parameter int CNT_W = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             update_en,
  input  logic             control_hazard,
  input  logic             rd_req,
  input  logic [1:0]       rd_sel,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    CLR  = 2'b11
  } state_t;

  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t state, state_n;

  logic [CNT_W-1:0] live_total, live_false, live_cycles;
  logic [CNT_W-1:0] snap_total, snap_false, snap_cycles;
  logic [CNT_W-1:0] total_n, false_n, cycles_n;
  logic [LEN_W-1:0] remaining;
  logic             sat_total, sat_false, cmd_err;
  logic             acc, start_ok, stop_ok, clear_ok;
  logic             close, err_set, hit;
  logic             tot_ovf, false_ovf;
  logic [CNT_W+4:0] status_w;

  always_comb begin
    cmd_ready = (state != CLR);
    acc       = cmd_valid && cmd_ready;
    clear_ok  = acc && (cmd_op == OP_CLEAR);
    start_ok  = acc && (cmd_op == OP_START)
                && (state == IDLE || state == HOLD);
    stop_ok   = acc && (cmd_op == OP_STOP) && (state == RUN);
    err_set   = acc && (((cmd_op == OP_START) && (state == RUN))
                || ((cmd_op == OP_STOP) && (state != RUN)));
    close     = (state == RUN) && !clear_ok
                && (stop_ok || remaining == LEN_ONE);
    state_n   = state;
    if (clear_ok)           state_n = CLR;
    else if (state == CLR)  state_n = IDLE;
    else if (start_ok)      state_n = RUN;
    else if (close)         state_n = HOLD;
  end

  // Counters stick at all-ones; an increment attempted there is an overflow.
  always_comb begin
    hit       = update_en && control_hazard;
    tot_ovf   = update_en && (live_total == CNT_MAX);
    false_ovf = hit && (live_false == CNT_MAX);
    total_n   = (update_en && !tot_ovf) ? live_total + CNT_ONE : live_total;
    false_n   = (hit && !false_ovf) ? live_false + CNT_ONE : live_false;
    cycles_n  = (live_cycles == CNT_MAX) ? live_cycles
                                         : live_cycles + CNT_ONE;
    status_w  = {{CNT_W{1'b0}}, cmd_err, sat_false, sat_total, state};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_total  <= '0;
      live_false  <= '0;
      live_cycles <= '0;
      snap_total  <= '0;
      snap_false  <= '0;
      snap_cycles <= '0;
      remaining   <= '0;
      sat_total   <= 1'b0;
      sat_false   <= 1'b0;
      cmd_err     <= 1'b0;
      done        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      done     <= close;
      rd_valid <= rd_req;
      if (rd_req) begin
        case (rd_sel)
          2'd0:    rd_data <= snap_total;
          2'd1:    rd_data <= snap_false;
          2'd2:    rd_data <= snap_cycles;
          default: rd_data <= status_w[CNT_W-1:0];
        endcase
      end
      if (clear_ok) begin
        live_total  <= '0;
        live_false  <= '0;
        live_cycles <= '0;
        snap_total  <= '0;
        snap_false  <= '0;
        snap_cycles <= '0;
        remaining   <= '0;
        sat_total   <= 1'b0;
        sat_false   <= 1'b0;
        cmd_err     <= 1'b0;
      end else begin
        if (err_set) cmd_err <= 1'b1;
        if (start_ok) begin
          live_total  <= '0;
          live_false  <= '0;
          live_cycles <= '0;
          remaining   <= cmd_len;
        end else if (state == RUN) begin
          live_total  <= total_n;
          live_false  <= false_n;
          live_cycles <= cycles_n;
          if (tot_ovf)   sat_total <= 1'b1;
          if (false_ovf) sat_false <= 1'b1;
          if (remaining != '0) remaining <= remaining - LEN_ONE;
          if (close) begin
            snap_total  <= total_n;
            snap_false  <= false_n;
            snap_cycles <= cycles_n;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_stat_ctrl.sv
// Bench: a 32-bit and a 4-bit instance share stimulus; a window-level
// model predicts both, and literal reads pin the model.
module tb_branch_stat_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic        update_en = 1'b0;
  logic        control_hazard = 1'b0;
  logic        rd_req = 1'b0;
  logic [1:0]  rd_sel = 2'd0;

  logic        rdy0, rv0, dn0;
  logic [31:0] rd0;
  logic        rdy1, rv1, dn1;
  logic [3:0]  rd1;

  int checks = 0;
  int failures = 0;
  bit run_chk = 1'b0;
  bit watch = 1'b0;
  int dn_seen = 0;

  always #5 clk = ~clk;

  branch_stat_ctrl #(.CNT_W(32), .LEN_W(8)) u_w32 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .update_en(update_en),
    .control_hazard(control_hazard), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rv0), .rd_data(rd0), .done(dn0)
  );

  branch_stat_ctrl #(.CNT_W(4), .LEN_W(8)) u_w4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .update_en(update_en),
    .control_hazard(control_hazard), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rv1), .rd_data(rd1), .done(dn1)
  );

  // Model: mode 0 idle, 1 counting, 2 holding, 3 clearing
  logic [31:0] m_lt[2], m_lf[2], m_lc[2];
  logic [31:0] m_st_t[2], m_st_f[2], m_st_c[2];
  logic [31:0] m_rd[2];
  int          m_mode[2], m_rem[2];
  bit          m_satt[2], m_satf[2], m_err[2], m_done[2], m_rv[2];

  function automatic logic [31:0] lim(input int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'd15;
  endfunction

  function automatic logic [31:0] status(input int i);
    return 32'(m_err[i]) * 16 + 32'(m_satf[i]) * 8
         + 32'(m_satt[i]) * 4 + 32'(m_mode[i]);
  endfunction

  task automatic m_zero(input int i);
    m_lt[i] = 0; m_lf[i] = 0; m_lc[i] = 0;
    m_st_t[i] = 0; m_st_f[i] = 0; m_st_c[i] = 0;
    m_rem[i] = 0; m_satt[i] = 0; m_satf[i] = 0; m_err[i] = 0;
  endtask

  task automatic m_step(input int i);
    bit acc;
    bit fin;
    m_done[i] = 1'b0;
    m_rv[i] = rd_req;
    if (rd_req) begin
      case (rd_sel)
        2'd0: m_rd[i] = m_st_t[i];
        2'd1: m_rd[i] = m_st_f[i];
        2'd2: m_rd[i] = m_st_c[i];
        default: m_rd[i] = status(i);
      endcase
    end
    acc = cmd_valid && (m_mode[i] != 3);
    if (acc && cmd_op == 2'd3) begin
      m_zero(i);
      m_mode[i] = 3;
    end else if (m_mode[i] == 3) begin
      m_mode[i] = 0;
    end else if (m_mode[i] == 1) begin
      if (m_lc[i] < lim(i)) m_lc[i] = m_lc[i] + 1;
      if (update_en) begin
        if (m_lt[i] == lim(i)) m_satt[i] = 1;
        else m_lt[i] = m_lt[i] + 1;
        if (control_hazard) begin
          if (m_lf[i] == lim(i)) m_satf[i] = 1;
          else m_lf[i] = m_lf[i] + 1;
        end
      end
      fin = (acc && cmd_op == 2'd2) || (m_rem[i] == 1);
      if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
      if (acc && cmd_op == 2'd1) m_err[i] = 1;
      if (fin) begin
        m_st_t[i] = m_lt[i];
        m_st_f[i] = m_lf[i];
        m_st_c[i] = m_lc[i];
        m_mode[i] = 2;
        m_done[i] = 1;
      end
    end else begin
      if (acc && cmd_op == 2'd1) begin
        m_lt[i] = 0; m_lf[i] = 0; m_lc[i] = 0;
        m_rem[i] = int'(cmd_len);
        m_mode[i] = 1;
      end
      if (acc && cmd_op == 2'd2) m_err[i] = 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_zero(i);
        m_mode[i] = 0; m_done[i] = 0; m_rv[i] = 0; m_rd[i] = 0;
      end else begin
        m_step(i);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("ready32", 32'(rdy0), 32'(m_mode[0] != 3));
      chk("done32", 32'(dn0), 32'(m_done[0]));
      chk("rvalid32", 32'(rv0), 32'(m_rv[0]));
      if (m_rv[0]) chk("rdata32", rd0, m_rd[0]);
      chk("ready4", 32'(rdy1), 32'(m_mode[1] != 3));
      chk("done4", 32'(dn1), 32'(m_done[1]));
      chk("rvalid4", 32'(rv1), 32'(m_rv[1]));
      if (m_rv[1]) chk("rdata4", 32'(rd1), {28'd0, m_rd[1][3:0]});
      if (watch && (dn0 || dn1)) dn_seen++;
    end
  end

  task automatic step(input bit v, input logic [1:0] op,
                      input logic [7:0] len, input bit ue, input bit ch,
                      input bit rq, input logic [1:0] sel);
    cmd_valid = v; cmd_op = op; cmd_len = len;
    update_en = ue; control_hazard = ch;
    rd_req = rq; rd_sel = sel;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 2'd0, 8'd0, 0, 0, 0, 2'd0);
  endtask

  task automatic rd(input logic [1:0] sel, input logic [31:0] e0,
                    input logic [3:0] e1);
    step(0, 2'd0, 8'd0, 0, 0, 1, sel);
    chk("lit_rd32", rd0, e0);
    chk("lit_rd4", 32'(rd1), 32'(e1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    @(negedge clk);
    run_chk = 1'b1;
    chk("lit_rst_ready", 32'(rdy0), 32'd1);
    chk("lit_rst_done", 32'(dn0), 32'd0);
    chk("lit_rst_rv", 32'(rv0), 32'd0);
    rst = 1'b0;
    idle();
    rd(2'd0, 32'd0, 4'd0);
    rd(2'd3, 32'd0, 4'd0);

    // 4-cycle window, hazards on 2 branches
    step(1, 2'd1, 8'd4, 0, 0, 0, 2'd0);
    step(0, 2'd0, 8'd0, 1, 1, 0, 2'd0);
    step(0, 2'd0, 8'd0, 1, 0, 0, 2'd0);
    step(0, 2'd0, 8'd0, 1, 1, 0, 2'd0);
    step(0, 2'd0, 8'd0, 1, 0, 0, 2'd0);
    chk("lit_done_len4", 32'(dn0), 32'd1);
    rd(2'd0, 32'd4, 4'd4);
    chk("lit_done_once", 32'(dn0), 32'd0);
    rd(2'd1, 32'd2, 4'd2);
    rd(2'd2, 32'd4, 4'd4);
    rd(2'd3, 32'd2, 4'd2);

    // unlimited window, START while counting, STOP with a branch
    step(1, 2'd3, 8'd0, 0, 0, 0, 2'd0);
    chk("lit_clr_ready_low", 32'(rdy0), 32'd0);
    idle();
    chk("lit_clr_ready_back", 32'(rdy0), 32'd1);
    step(1, 2'd1, 8'd0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 12; i++)
      step(i == 6, 2'd1, 8'd9, (i != 3) && (i != 7),
           (i == 1) || (i == 5) || (i == 9), 1, 2'd0);
    step(1, 2'd2, 8'd0, 1, 0, 0, 2'd0);
    chk("lit_done_stop", 32'(dn0), 32'd1);
    rd(2'd0, 32'd11, 4'd11);
    chk("lit_stop_once", 32'(dn0), 32'd0);
    rd(2'd1, 32'd3, 4'd3);
    rd(2'd2, 32'd13, 4'd13);
    rd(2'd3, 32'd18, 4'd2);

    // expiry and STOP land on the same cycle
    step(1, 2'd1, 8'd3, 0, 0, 0, 2'd0);
    step(0, 2'd0, 8'd0, 1, 0, 1, 2'd0);
    step(0, 2'd0, 8'd0, 0, 0, 1, 2'd2);
    step(1, 2'd2, 8'd0, 1, 1, 1, 2'd1);
    chk("lit_done_both", 32'(dn0), 32'd1);
    rd(2'd0, 32'd2, 4'd2);
    chk("lit_both_once", 32'(dn0), 32'd0);
    rd(2'd1, 32'd1, 4'd1);
    rd(2'd2, 32'd3, 4'd3);

    // STOP while idle
    step(1, 2'd3, 8'd0, 0, 0, 0, 2'd0);
    idle();
    step(1, 2'd2, 8'd0, 1, 1, 0, 2'd0);
    rd(2'd3, 32'd16, 4'd0);
    rd(2'd0, 32'd0, 4'd0);

    // saturation of the narrow instance
    step(1, 2'd3, 8'd0, 0, 0, 0, 2'd0);
    idle();
    step(1, 2'd1, 8'd0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 20; i++)
      step(0, 2'd0, 8'd0, 1, 1, (i % 3) == 0, 2'(i));
    step(1, 2'd2, 8'd0, 0, 0, 0, 2'd0);
    rd(2'd0, 32'd20, 4'd15);
    rd(2'd1, 32'd20, 4'd15);
    rd(2'd3, 32'd2, 4'd14);
    step(1, 2'd3, 8'd0, 0, 0, 0, 2'd0);
    chk("lit_sat_clr_ready", 32'(rdy1), 32'd0);
    idle();
    rd(2'd3, 32'd0, 4'd0);
    rd(2'd0, 32'd0, 4'd0);

    // previous window stays readable, then reset mid-run
    step(1, 2'd1, 8'd5, 0, 0, 0, 2'd0);
    step(0, 2'd0, 8'd0, 1, 1, 0, 2'd0);
    step(0, 2'd0, 8'd0, 1, 0, 0, 2'd0);
    watch = 1'b1;
    step(0, 2'd0, 8'd0, 1, 1, 0, 2'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("lit_rst_mid_ready", 32'(rdy0), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      rd(2'(i), 32'd0, 4'd0);
    repeat (4) idle();
    chk("lit_no_done_after_rst", 32'(dn_seen), 32'd0);
    watch = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_stat_ctrl.md
BRANCH_STAT_CTRL -- requirements
Module: branch_stat_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of all event/cycle counters and of rd_data.
REQ-002 SHALL have parameter LEN_W, default 16: width of the window-length field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
REQ-007 SHALL have port cmd_op  input  2  command: 00 NOP, 01 START, 10 STOP, 11 CLEAR.
REQ-008 SHALL have port cmd_len  input  LEN_W  window length in cycles for START; 0 = unlimited.
REQ-009 SHALL have port update_en  input  1  a branch resolved this cycle.
REQ-010 SHALL have port control_hazard  input  1  the resolved branch was mispredicted; qualified by update_en.
REQ-011 SHALL have port rd_req  input  1  read request.
REQ-012 SHALL have port rd_sel  input  2  register select: 0 snap_total, 1 snap_false, 2 snap_cycles, 3 status.
REQ-013 SHALL have port rd_valid  output  1  rd_data valid.
REQ-014 SHALL have port rd_data  output  CNT_W  read data.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a window closes.

Function
REQ-016 SHALL implement states IDLE(00), RUN(01), HOLD(10), CLR(11).
REQ-017 cmd_ready SHALL be 1 in IDLE, RUN, HOLD and 0 in CLR (combinational from state).
REQ-018 START accepted in IDLE/HOLD SHALL zero live_total, live_false, live_cycles, load remaining=cmd_len, enter RUN next cycle; events in the accept cycle are not counted.
REQ-019 START accepted in RUN SHALL be ignored and set sticky cmd_err.
REQ-020 In RUN, each cycle SHALL increment live_cycles, increment live_total if update_en, increment live_false if update_en&&control_hazard.
REQ-021 control_hazard with update_en=0 SHALL never change any counter.
REQ-022 Each live counter SHALL saturate at all-ones; saturation of live_total/live_false SHALL set sticky sat_total/sat_false.
REQ-023 With remaining!=0, remaining SHALL decrement each RUN cycle; in the RUN cycle where remaining==1, that cycle's events SHALL be counted, snapshot taken, state->HOLD, done=1 next cycle.
REQ-024 With remaining==0 (unlimited), RUN SHALL persist until STOP or CLEAR.
REQ-025 STOP accepted in RUN SHALL snapshot live values including the STOP cycle's events, go to HOLD, pulse done; STOP in IDLE/HOLD SHALL be ignored and set cmd_err.
REQ-026 Window expiry and STOP in the same cycle SHALL produce one snapshot and one done pulse.
REQ-027 CLEAR accepted in any state SHALL enter CLR for exactly one cycle, zero live and snapshot registers, sat_total, sat_false, cmd_err, then enter IDLE.
REQ-028 Snapshot registers snap_total/snap_false/snap_cycles SHALL change only at window close or CLEAR.
REQ-029 rd_req SHALL be serviced in any state: rd_valid=1 and rd_data registered one cycle after rd_req, else rd_valid=0; back-to-back reads allowed each cycle.
REQ-030 Status word SHALL be {zeros, cmd_err[4], sat_false[3], sat_total[2], state[1:0]}.
REQ-031 A snapshot and a read in the same cycle SHALL return the pre-snapshot value.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, all counters, snapshots, flags, remaining, done, rd_valid, rd_data to 0; cmd_ready=1 once IDLE.
REQ-033 rst asserted mid-RUN SHALL discard the window; no done pulse.

Verification
REQ-034 START len=4; update_en=1 every cycle, control_hazard=1 on 2 of them -> done after 4 RUN cycles; reads give total=4, false=2, cycles=4, state=HOLD.
REQ-035 START len=0; 10 branches, 3 mispredicts; STOP with update_en=1 on STOP cycle -> total=11, cycles includes STOP cycle, one done.
REQ-036 Force live_total near all-ones (CNT_W=4 build), 20 branches -> total=15, sat_total=1; CLEAR -> status=0, cmd_ready low one cycle.
REQ-037 STOP in IDLE and START in RUN -> ignored, cmd_err=1, counters unaffected.
REQ-038 rst pulse mid-RUN -> all reads return 0, state IDLE, done never asserted.
